// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Purpose:
//   Walks the user through one register-file operation entered on switches
//   and a pushbutton: opcode, then register A, then register B. It then
//   runs the shared ALU, writes the result back into register A, and holds
//   the result for the display logic. This block owns the 8x8-bit register
//   file.
//
// Optional feature macro:
//   DEBOUNCE_EN - when defined, a press is accepted only once the
//                 synchronised button has been stable for DEBOUNCE_CYCLES
//                 cycles. Short glitches are then rejected.
//
// Ports:
//   clock     in   1  system clock, rising-edge active
//   reset_n   in   1  synchronous active-low reset
//   setButton in   1  active-low pushbutton, asynchronous to clock
//   inputs    in   4  switch value captured on a press
//   readSel   in   3  register index for the display view
//   readData  out  8  combinational view of regfile[readSel]
//   state     out  3  current FSM state code
//   opCode    out  4  latched opcode
//   regA      out  3  latched destination / first-operand index
//   regB      out  3  latched second-operand index
//   result    out  8  last ALU result
//   carry     out  1  carry / borrow flag
//   zero      out  1  zero flag
//   badOp     out  1  last executed opcode was reserved (8..15)
//   busy      out  1  high while in EXEC and WB
//   done      out  1  one-cycle pulse on entry to SHOW
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int         NUM_REGS  = 8,
  parameter logic [7:0] REG_RESET = 8'h01
`ifdef DEBOUNCE_EN
  ,
  parameter int         DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       setButton,
  input  logic [3:0] inputs,
  input  logic [2:0] readSel,
  output logic [7:0] readData,
  output logic [2:0] state,
  output logic [3:0] opCode,
  output logic [2:0] regA,
  output logic [2:0] regB,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero,
  output logic       badOp,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_OP   = 3'd0,
    ST_RA   = 3'd1,
    ST_RB   = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_SHOW = 3'd5
  } state_e;

  state_e      state_q;
  logic [3:0]  opCode_q;
  logic [2:0]  regA_q;
  logic [2:0]  regB_q;
  logic [7:0]  result_q;
  logic        carry_q;
  logic        zero_q;
  logic        badOp_q;
  logic        done_q;
  logic [8:0]  aluSum_q;
  logic [8:0]  aluSum_d;
  logic [7:0]  regs_q [NUM_REGS];

  logic        sync1_q;
  logic        sync2_q;
  logic        sync2Prev_q;
  logic        press;

  logic [7:0]  opA;
  logic [7:0]  opB;

  // Two-flop synchronizer for the asynchronous button, plus one more stage
  // so a falling edge of the synchronised level can be seen. The button
  // idles high, so every stage resets to 1 and no press appears after
  // reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync2Prev_q <= 1'b1;
    end else begin
      sync1_q     <= setButton;
      sync2_q     <= sync1_q;
      sync2Prev_q <= sync2_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] stableCnt_q;
  logic             dbLevel_q;
  logic             stableNow;

  // The counter measures how long sync2 has held its value. It restarts on
  // any change and saturates at CNT_FULL. Once it is full, the debounced
  // level follows sync2. A press is the debounced level going high-to-low,
  // so the low level must persist for the full window first.
  assign stableNow = (stableCnt_q == CNT_FULL) && (sync2_q == sync2Prev_q);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stableCnt_q <= CNT_FULL;
      dbLevel_q   <= 1'b1;
    end else begin
      if (sync2_q != sync2Prev_q) begin
        stableCnt_q <= '0;
      end else if (stableCnt_q != CNT_FULL) begin
        stableCnt_q <= stableCnt_q + CNT_W'(1);
      end
      if (stableNow) begin
        dbLevel_q <= sync2_q;
      end
    end
  end

  assign press = stableNow & dbLevel_q & ~sync2_q;
`else
  // A press is a single-cycle pulse on the falling edge of the
  // synchronised button, so holding the button gives one press.
  assign press = sync2Prev_q & ~sync2_q;
`endif

  // The ALU works on the latched operand indices. Its result is captured
  // in EXEC as a 9-bit value: bit 8 carries the carry/borrow out.
  assign opA = regs_q[regA_q];
  assign opB = regs_q[regB_q];

  always_comb begin
    aluSum_d = '0;
    case (opCode_q[2:0])
      3'd0: aluSum_d = {1'b0, opA} + {1'b0, opB};
      3'd1: aluSum_d = {1'b0, opA} - {1'b0, opB};
      3'd2: aluSum_d = {1'b0, opA & opB};
      3'd3: aluSum_d = {1'b0, opA | opB};
      3'd4: aluSum_d = {1'b0, opA ^ opB};
      3'd5: aluSum_d = {1'b0, opB};
      3'd6: aluSum_d = {opA[7], opA[6:0], 1'b0};
      3'd7: aluSum_d = {opA[0], 1'b0, opA[7:1]};
    endcase
  end

  // Main sequencer. Reset is checked first, so it wins over a press in the
  // same cycle. Presses outside OP/RA/RB/SHOW are dropped, not queued.
  // Reserved opcodes (bit 3 set) only raise badOp. They leave the register
  // file, the result and the flags untouched.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_OP;
      opCode_q <= '0;
      regA_q   <= '0;
      regB_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      badOp_q  <= 1'b0;
      done_q   <= 1'b0;
      aluSum_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= REG_RESET;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_OP: begin
          if (press) begin
            opCode_q <= inputs;
            state_q  <= ST_RA;
          end
        end
        ST_RA: begin
          if (press) begin
            regA_q  <= inputs[2:0];
            state_q <= ST_RB;
          end
        end
        ST_RB: begin
          if (press) begin
            regB_q  <= inputs[2:0];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          aluSum_q <= aluSum_d;
          state_q  <= ST_WB;
        end
        ST_WB: begin
          if (opCode_q[3]) begin
            badOp_q <= 1'b1;
          end else begin
            result_q       <= aluSum_q[7:0];
            carry_q        <= aluSum_q[8];
            zero_q         <= (aluSum_q[7:0] == 8'h00);
            badOp_q        <= 1'b0;
            regs_q[regA_q] <= aluSum_q[7:0];
          end
          done_q  <= 1'b1;
          state_q <= ST_SHOW;
        end
        ST_SHOW: begin
          if (press) begin
            state_q <= ST_OP;
          end
        end
        default: begin
          state_q <= ST_OP;
        end
      endcase
    end
  end

  assign readData = regs_q[readSel];
  assign state    = state_q;
  assign opCode   = opCode_q;
  assign regA     = regA_q;
  assign regB     = regB_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign badOp    = badOp_q;
  assign done     = done_q;
  assign busy     = (state_q == ST_EXEC) || (state_q == ST_WB);

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed bench for cpu_sequencer. A table of complete operations
// (opcode, A, B, expected result/flags/written value) runs in a loop.
// Hand-written sequences then cover the long press, presses during WB,
// reset in WB and, with DEBOUNCE_EN, glitch rejection.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

`ifdef DEBOUNCE_EN
  localparam int GAP = 24;
  localparam int LAT = 20;
`else
  localparam int GAP = 3;
  localparam int LAT = 3;
`endif

  logic       clock;
  logic       reset_n;
  logic       setButton;
  logic [3:0] inputs;
  logic [2:0] readSel;
  logic [7:0] readData;
  logic [2:0] state;
  logic [3:0] opCode;
  logic [2:0] regA;
  logic [2:0] regB;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       badOp;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       bad;
    logic [7:0] wrVal;
  } vec_t;

  vec_t       vecs [21];
  logic [7:0] finalRegs [8];

  cpu_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .setButton (setButton),
    .inputs    (inputs),
    .readSel   (readSel),
    .readData  (readData),
    .state     (state),
    .opCode    (opCode),
    .regA      (regA),
    .regB      (regB),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .badOp     (badOp),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one cycle and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One comparison. Mismatches are reported and counted.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Press and hold the button with the given switch value until the FSM
  // moves, then release and leave the button idle long enough to re-arm.
  task automatic applyStimulus(input logic [3:0] val);
    logic [2:0] startState;
    int         n;
    startState = state;
    inputs     = val;
    setButton  = 1'b0;
    n          = 0;
    do begin
      tick();
      n++;
    end while (state == startState && n < 200);
    checkOutput("pressSeen", 32'(state != startState), 32'd1);
    setButton = 1'b1;
    repeat (GAP) tick();
  endtask

  // Run one full operation from OP through SHOW and back to OP, checking
  // latency, the done pulse, the flags and the written register.
  task automatic runOp(input vec_t v, input int idx);
    int n;
    applyStimulus(v.op);
    checkOutput($sformatf("v%0d.stateRA", idx), 32'(state), 32'd1);
    applyStimulus({1'b1, v.ra});
    checkOutput($sformatf("v%0d.stateRB", idx), 32'(state), 32'd2);
    checkOutput($sformatf("v%0d.regA", idx), 32'(regA), 32'(v.ra));
    inputs    = {1'b0, v.rb};
    setButton = 1'b0;
    n         = 0;
    do begin
      tick();
      n++;
    end while (state != 3'd3 && n < 200);
    checkOutput($sformatf("v%0d.execLatency", idx), 32'(n), 32'(LAT));
    checkOutput($sformatf("v%0d.busyExec", idx), 32'(busy), 32'd1);
    tick();
    checkOutput($sformatf("v%0d.stateWB", idx), 32'(state), 32'd4);
    checkOutput($sformatf("v%0d.doneEarly", idx), 32'(done), 32'd0);
    tick();
    checkOutput($sformatf("v%0d.stateShow", idx), 32'(state), 32'd5);
    checkOutput($sformatf("v%0d.done", idx), 32'(done), 32'd1);
    checkOutput($sformatf("v%0d.result", idx), 32'(result), 32'(v.res));
    checkOutput($sformatf("v%0d.carry", idx), 32'(carry), 32'(v.c));
    checkOutput($sformatf("v%0d.zero", idx), 32'(zero), 32'(v.z));
    checkOutput($sformatf("v%0d.badOp", idx), 32'(badOp), 32'(v.bad));
    tick();
    checkOutput($sformatf("v%0d.doneOnce", idx), 32'(done), 32'd0);
    setButton = 1'b1;
    repeat (GAP) tick();
    readSel = v.ra;
    #1;
    checkOutput($sformatf("v%0d.regWrite", idx), 32'(readData), 32'(v.wrVal));
    applyStimulus(4'd0);
    checkOutput($sformatf("v%0d.backToOp", idx), 32'(state), 32'd0);
    checkOutput($sformatf("v%0d.opKept", idx), 32'(opCode), 32'(v.op));
    checkOutput($sformatf("v%0d.regBKept", idx), 32'(regB), 32'(v.rb));
    checkOutput($sformatf("v%0d.resultKept", idx), 32'(result), 32'(v.res));
  endtask

  // Main test sequence.
  initial begin
    int  n;
    bit  sawDone;

    //           op     ra    rb    res    c     z     bad   wrVal
    vecs[0]  = '{4'h1, 3'd7, 3'd6, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{4'h1, 3'd7, 3'd6, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[2]  = '{4'h6, 3'd7, 3'd0, 8'hFE, 1'b1, 1'b0, 1'b0, 8'hFE};
    vecs[3]  = '{4'h6, 3'd7, 3'd0, 8'hFC, 1'b1, 1'b0, 1'b0, 8'hFC};
    vecs[4]  = '{4'h6, 3'd7, 3'd0, 8'hF8, 1'b1, 1'b0, 1'b0, 8'hF8};
    vecs[5]  = '{4'h6, 3'd7, 3'd0, 8'hF0, 1'b1, 1'b0, 1'b0, 8'hF0};
    vecs[6]  = '{4'h5, 3'd1, 3'd7, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0};
    vecs[7]  = '{4'h0, 3'd1, 3'd1, 8'hE0, 1'b1, 1'b0, 1'b0, 8'hE0};
    vecs[8]  = '{4'h1, 3'd2, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{4'h1, 3'd2, 3'd4, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[10] = '{4'hA, 3'd5, 3'd6, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h01};
    vecs[11] = '{4'h0, 3'd5, 3'd6, 8'h02, 1'b0, 1'b0, 1'b0, 8'h02};
    vecs[12] = '{4'h2, 3'd1, 3'd2, 8'hE0, 1'b0, 1'b0, 1'b0, 8'hE0};
    vecs[13] = '{4'h3, 3'd0, 3'd5, 8'h03, 1'b0, 1'b0, 1'b0, 8'h03};
    vecs[14] = '{4'h4, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[15] = '{4'h7, 3'd5, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[16] = '{4'h7, 3'd5, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[17] = '{4'h0, 3'd2, 3'd6, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[18] = '{4'h5, 3'd3, 3'd1, 8'hE0, 1'b0, 1'b0, 1'b0, 8'hE0};
    vecs[19] = '{4'hF, 3'd3, 3'd3, 8'hE0, 1'b0, 1'b0, 1'b1, 8'hE0};
    vecs[20] = '{4'h1, 3'd4, 3'd3, 8'h21, 1'b1, 1'b0, 1'b0, 8'h21};

    finalRegs = '{8'h00, 8'hE0, 8'h00, 8'hE0, 8'h21, 8'h00, 8'h01, 8'hF0};

    reset_n   = 1'b0;
    setButton = 1'b1;
    inputs    = 4'd0;
    readSel   = 3'd0;
    repeat (3) tick();

    // Reset state.
    checkOutput("rstState", 32'(state), 32'd0);
    checkOutput("rstResult", 32'(result), 32'd0);
    checkOutput("rstCarry", 32'(carry), 32'd0);
    checkOutput("rstZero", 32'(zero), 32'd0);
    checkOutput("rstBadOp", 32'(badOp), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOpCode", 32'(opCode), 32'd0);
    checkOutput("rstRegA", 32'(regA), 32'd0);
    checkOutput("rstRegB", 32'(regB), 32'd0);
    for (int i = 0; i < 8; i++) begin
      readSel = 3'(i);
      #1;
      checkOutput($sformatf("rstReg%0d", i), 32'(readData), 32'h01);
    end

    reset_n = 1'b1;
    repeat (GAP) tick();

    for (int i = 0; i < 21; i++) begin
      runOp(vecs[i], i);
    end

    for (int i = 0; i < 8; i++) begin
      readSel = 3'(i);
      #1;
      checkOutput($sformatf("finalReg%0d", i), 32'(readData), 32'(finalRegs[i]));
    end

    // A 50-cycle hold in OP must give exactly one step, to RA.
    inputs    = 4'd5;
    setButton = 1'b0;
    repeat (50) tick();
    checkOutput("holdState", 32'(state), 32'd1);
    checkOutput("holdOpCode", 32'(opCode), 32'd5);
    setButton = 1'b1;
    repeat (GAP) tick();
    checkOutput("holdRelease", 32'(state), 32'd1);
    applyStimulus(4'd4);
    checkOutput("movRB", 32'(state), 32'd2);

`ifndef DEBOUNCE_EN
    // Short pulses: the press that leaves RB is followed by a second
    // press that lands in WB and must be dropped.
    inputs    = 4'd6;
    setButton = 1'b0;
    tick();
    setButton = 1'b1;
    tick();
    checkOutput("glitchPending", 32'(state), 32'd2);
    setButton = 1'b0;
    tick();
    checkOutput("glitchExec", 32'(state), 32'd3);
    setButton = 1'b1;
    tick();
    checkOutput("glitchWB", 32'(state), 32'd4);
    tick();
    checkOutput("glitchShow", 32'(state), 32'd5);
    checkOutput("glitchDone", 32'(done), 32'd1);
    checkOutput("glitchResult", 32'(result), 32'h01);
    tick();
    checkOutput("wbPressDropped", 32'(state), 32'd5);
    repeat (GAP) tick();
    checkOutput("wbPressNotQueued", 32'(state), 32'd5);
`else
    inputs    = 4'd6;
    setButton = 1'b0;
    n         = 0;
    do begin
      tick();
      n++;
    end while (state != 3'd5 && n < 200);
    checkOutput("movShow", 32'(state), 32'd5);
    checkOutput("movDone", 32'(done), 32'd1);
    checkOutput("movResult", 32'(result), 32'h01);
    setButton = 1'b1;
    repeat (GAP) tick();
`endif
    readSel = 3'd4;
    #1;
    checkOutput("movReg4", 32'(readData), 32'h01);
    applyStimulus(4'd0);
    checkOutput("movBackToOp", 32'(state), 32'd0);

`ifdef DEBOUNCE_EN
    // A 5-cycle glitch is shorter than the debounce window.
    setButton = 1'b0;
    repeat (5) tick();
    setButton = 1'b1;
    repeat (GAP) tick();
    checkOutput("glitchRejected", 32'(state), 32'd0);
`endif

    // Reset during WB: the write to r3 (E0 + E0) must never land.
    applyStimulus(4'd0);
    applyStimulus(4'd3);
    inputs    = 4'd3;
    setButton = 1'b0;
    n         = 0;
    do begin
      tick();
      n++;
    end while (state != 3'd3 && n < 200);
    tick();
    checkOutput("rwbInWB", 32'(state), 32'd4);
    reset_n   = 1'b0;
    setButton = 1'b1;
    tick();
    checkOutput("rwbState", 32'(state), 32'd0);
    checkOutput("rwbDone", 32'(done), 32'd0);
    checkOutput("rwbResult", 32'(result), 32'd0);
    checkOutput("rwbCarry", 32'(carry), 32'd0);
    readSel = 3'd3;
    #1;
    checkOutput("rwbReg3", 32'(readData), 32'h01);
    reset_n = 1'b1;
    sawDone = 1'b0;
    repeat (GAP + 4) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    checkOutput("rwbNoDone", 32'(sawDone), 32'd0);
    checkOutput("rwbStayOp", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Sequences one operation on the CPU's 8x8-bit register file from switch and button input. The user enters an opcode, then register A, then register B. The block then executes on the shared ALU, writes back to register A, and holds the result for display. It sits between the switch/button pins and the 7-segment display formatting logic, and it owns the register file.

Parameters:
- NUM_REGS, 8, register file depth (fixed 8; index width 3)
- REG_RESET, 8'h01, reset value of every register
- DEBOUNCE_CYCLES, 16, stable-sample count for setButton (used only with DEBOUNCE_EN)

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset_n  input  1  synchronous, active-low reset
- setButton  input  1  active-low pushbutton, asynchronous to clock
- inputs  input  4  switch value latched on a press
- readSel  input  3  register index for the display view
- readData  output  8  combinational view: regfile[readSel]
- state  output  3  current FSM state code
- opCode  output  4  latched opcode
- regA  output  3  latched destination/first-operand index
- regB  output  3  latched second-operand index
- result  output  8  last ALU result
- carry  output  1  carry/borrow flag
- zero  output  1  zero flag
- badOp  output  1  last executed opcode was reserved
- busy  output  1  high in EXEC and WB
- done  output  1  one-cycle pulse on entry to SHOW

Behaviour:
- Reset (reset_n low at a rising edge): state=OP, opCode=0, regA=0, regB=0, result=0, carry=0, zero=0, badOp=0, done=0, all registers=REG_RESET. Reset wins over any simultaneous press.
- Press detect: setButton passes through a 2-flop synchronizer; press = sync2 was 1 last cycle and is 0 now. press is a single-cycle pulse, so holding the button gives exactly one press.
- FSM codes: OP=0, RA=1, RB=2, EXEC=3, WB=4, SHOW=5. Codes 6 and 7 go to OP on the next edge.
- OP: on press, opCode<=inputs; go to RA.
- RA: on press, regA<=inputs[2:0]; inputs[3] ignored; go to RB.
- RB: on press, regB<=inputs[2:0]; go to EXEC.
- EXEC: unconditional, 1 cycle. Compute A=regfile[regA], B=regfile[regB] into an internal 9-bit sum; go to WB.
- WB: unconditional, 1 cycle. result, flags and regfile[regA] update at the end of WB; go to SHOW.
- SHOW: done=1 on the first SHOW cycle only. On press, go to OP; opCode/regA/regB/result keep their values.
- Presses in EXEC and WB are ignored and are not queued.
- Latency: press in RB at cycle t gives EXEC at t+1, WB at t+2, SHOW with the new result and done at t+3.
- Opcodes (modulo-256 arithmetic):
  - 0 ADD: A+B; carry=bit 8
  - 1 SUB: A-B; carry=borrow (1 if A<B unsigned)
  - 2 AND; 3 OR; 4 XOR: carry=0
  - 5 MOV: B; carry=0
  - 6 SHL: A<<1; carry=A[7]
  - 7 SHR: A>>1 logical; carry=A[0]
  - zero = (result==0) for all valid ops
- Opcodes 8-15: no register write; result, carry and zero are unchanged; badOp=1. Any valid op clears badOp.
- regA==regB is legal; both operands read the pre-write value.
- readData is combinational and shows the written value from the cycle after WB.

Optional Feature:
- DEBOUNCE_EN defined: press additionally requires sync2 to have been stable for DEBOUNCE_CYCLES consecutive cycles before the falling edge is accepted. A debounce counter resets on any change of sync2. This adds DEBOUNCE_CYCLES cycles of press latency; bounces shorter than that produce no press.
- Not defined: raw synchronizer edge detect as described in Behaviour.

Test Plan:
- Reset, then readSel=0..7 -> readData=8'h01 for every register; state=0, result=0, carry=0, zero=0.
- Preload r1=8'hF0 (via MOV chains). ADD with regA=1, regB=1 -> result=8'hE0, carry=1, zero=0, r1=8'hE0; done pulses exactly 3 cycles after the RB press.
- SUB with regA=2, regB=3 (both 8'h01) -> result=8'h00, zero=1, carry=0; SUB r2-r4 with r2=0, r4=1 -> result=8'hFF, carry=1.
- Opcode 4'b1010 -> no register changes, badOp=1, previous result and flags retained; a following valid ADD clears badOp.
- Hold setButton low for 50 cycles in OP -> exactly one transition, to RA. Presses during EXEC/WB -> ignored; SHOW reached normally.
- reset_n low during WB -> next cycle state=OP, target register=8'h01, done never pulses. With DEBOUNCE_EN: a 5-cycle low glitch produces no press.
